sram_burst_master: RTL and testbench

//  Initiator for one single_port_ram port (ce/we/din/adr/dout): converts burst commands
//  (start address, beat count, read/write) into one RAM access per cycle. Sits between a

---
 rtl/sram_burst_master.sv | 109 ++++++++++
 tb/tb_sram_burst_master.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_burst_master.sv
// sram_burst_master: turns burst commands into one single-port RAM access per cycle.
// Define RAM_INIT_CLEAR_EN to zero the whole RAM right after reset release.
module sram_burst_master #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_we_i,
   input  logic [AWIDTH-1:0] cmd_addr_i,
   input  logic [AWIDTH-1:0] cmd_len_i,
   input  logic              wr_valid_i,
   output logic              wr_ready_o,
   input  logic [DWIDTH-1:0] wr_data_i,
   output logic              rd_valid_o,
   output logic [DWIDTH-1:0] rd_data_o,
   output logic              busy_o,
   output logic              ram_ce_o,
   output logic              ram_we_o,
   output logic [AWIDTH-1:0] ram_adr_o,
   output logic [DWIDTH-1:0] ram_din_o,
   input  logic [DWIDTH-1:0] ram_dout_i
);
   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, CLEAR} state_e;
   localparam logic [AWIDTH-1:0] ONE = AWIDTH'(1);
`ifdef RAM_INIT_CLEAR_EN
   localparam state_e RST_STATE = CLEAR;
`else
   localparam state_e RST_STATE = IDLE;
`endif
   state_e            state_q;
   logic [AWIDTH-1:0] addr_q, rem_q, adr_q;
   logic [DWIDTH-1:0] din_q;
   logic              ce_q, we_q;
   logic [RD_LAT-1:0] pipe_q, pipe_d;
   // one bit per read access in flight; the top bit is the beat whose data is on ram_dout
   assign pipe_d      = (pipe_q << 1) | RD_LAT'(ce_q & ~we_q);
   assign rd_valid_o  = pipe_q[RD_LAT-1];
   assign rd_data_o   = ram_dout_i;
   assign cmd_ready_o = state_q == IDLE;
   assign wr_ready_o  = state_q == WRITE;
   assign busy_o      = (state_q != IDLE) || (|pipe_q);
   assign ram_ce_o    = ce_q;
   assign ram_we_o    = we_q;
   assign ram_adr_o   = adr_q;
   assign ram_din_o   = din_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RST_STATE;
         addr_q  <= '0;
         rem_q   <= '0;
         adr_q   <= '0;
         din_q   <= '0;
         ce_q    <= 1'b0;
         we_q    <= 1'b0;
         pipe_q  <= '0;
      end else begin
         pipe_q <= pipe_d;
         ce_q   <= 1'b0;
         we_q   <= 1'b0;
         case (state_q)
            IDLE: if (cmd_valid_i) begin
               rem_q <= cmd_len_i;
               if (cmd_we_i) begin
                  addr_q  <= cmd_addr_i;
                  state_q <= WRITE;
               end else begin
                  // the first read goes out straight from acceptance
                  ce_q    <= 1'b1;
                  adr_q   <= cmd_addr_i;
                  addr_q  <= cmd_addr_i + ONE;
                  state_q <= (cmd_len_i == '0) ? DRAIN : READ;
               end
            end
            WRITE: if (wr_valid_i) begin
               ce_q   <= 1'b1;
               we_q   <= 1'b1;
               adr_q  <= addr_q;
               din_q  <= wr_data_i;
               addr_q <= addr_q + ONE;
               rem_q  <= rem_q - ONE;
               if (rem_q == '0) state_q <= IDLE;
            end
            READ: begin
               ce_q   <= 1'b1;
               adr_q  <= addr_q;
               addr_q <= addr_q + ONE;
               rem_q  <= rem_q - ONE;
               if (rem_q == ONE) state_q <= DRAIN;
            end
            DRAIN: if (pipe_d == '0) state_q <= IDLE;
`ifdef RAM_INIT_CLEAR_EN
            CLEAR: begin
               ce_q   <= 1'b1;
               we_q   <= 1'b1;
               adr_q  <= addr_q;
               din_q  <= '0;
               addr_q <= addr_q + ONE;
               if (&addr_q) state_q <= IDLE;
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_burst_master.sv
// tb_sram_burst_master: directed bench with a 1-cycle-latency RAM model on the RAM port.
module tb_sram_burst_master;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
   logic [3:0] cmd_addr = '0, cmd_len = '0;
   logic       wr_valid = 1'b0, wr_ready;
   logic [7:0] wr_data = '0, rd_data, ram_din, ram_dout;
   logic       rd_valid, busy, ram_ce, ram_we;
   logic [3:0] ram_adr;
   int         n_chk = 0, n_fail = 0, cyc = 0, bad_busy = 0;
   logic [7:0] mem [16];
   logic [3:0] wa[$], ra[$];
   logic [7:0] wd[$], rd[$], ex[$];
   int         ac[$], rc[$];

   sram_burst_master #(.DWIDTH(8), .AWIDTH(4), .RD_LAT(1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_we_i(cmd_we), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .wr_valid_i(wr_valid),
      .wr_ready_o(wr_ready), .wr_data_i(wr_data), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
      .busy_o(busy), .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_adr_o(ram_adr),
      .ram_din_o(ram_din), .ram_dout_i(ram_dout));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial foreach (mem[i]) mem[i] = 8'hEE;
   always @(posedge clk) if (ram_ce) begin
      if (ram_we) mem[ram_adr] <= ram_din;
      else ram_dout <= mem[ram_adr];
   end

   always @(negedge clk) begin
      if (ram_ce && ram_we) begin wa.push_back(ram_adr); wd.push_back(ram_din); end
      if (ram_ce && !ram_we) begin ra.push_back(ram_adr); ac.push_back(cyc); end
      if (rd_valid) begin
         rd.push_back(rd_data); rc.push_back(cyc);
         if (!busy) bad_busy++;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic clr();
      wa.delete(); wd.delete(); ra.delete(); rd.delete(); ac.delete(); rc.delete();
      bad_busy = 0;
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while (busy && t < 600) begin step(); t++; end
      chk({tag, "_idle"}, int'(busy), 0);
   endtask

   task automatic send_cmd(input logic we, input logic [3:0] a, input logic [3:0] l);
      int t = 0;
      while (!cmd_ready && t < 600) begin step(); t++; end
      chk("cmd_ready_wait", int'(cmd_ready), 1);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = l;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wr_beat(input logic [7:0] d);
      wr_valid = 1'b1; wr_data = d;
      chk("wr_ready", int'(wr_ready), 1);
      step();
      wr_valid = 1'b0;
   endtask

   task automatic write_burst(input string tag, input logic [3:0] a, input logic [3:0] l);
      clr();
      send_cmd(1'b1, a, l);
      foreach (ex[i]) wr_beat(ex[i]);
      chk({tag, "_last_ce"}, int'(ram_ce), 1);
      chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
      chk({tag, "_wr_ready_off"}, int'(wr_ready), 0);
      step();
      chk({tag, "_ce_off"}, int'(ram_ce), 0);
      chk({tag, "_nwr"}, wa.size(), int'(l) + 1);
      for (int i = 0; i < wa.size() && i < ex.size(); i++) begin
         chk($sformatf("%s_adr%0d", tag, i), int'(wa[i]), int'(4'(a + 4'(i))));
         chk($sformatf("%s_din%0d", tag, i), int'(wd[i]), int'(ex[i]));
      end
   endtask

   task automatic read_check(input string tag, input logic [3:0] a, input logic [3:0] l);
      int k;
      clr();
      send_cmd(1'b0, a, l);
      k = cyc;
      wait_idle(tag);
      chk({tag, "_nrd"}, rd.size(), int'(l) + 1);
      chk({tag, "_nacc"}, ra.size(), int'(l) + 1);
      if (ac.size() > 0) chk({tag, "_first_acc"}, ac[0], k);
      for (int i = 0; i < rd.size() && i < ex.size() && i < ra.size(); i++) begin
         chk($sformatf("%s_data%0d", tag, i), int'(rd[i]), int'(ex[i]));
         chk($sformatf("%s_adr%0d", tag, i), int'(ra[i]), int'(4'(a + 4'(i))));
         chk($sformatf("%s_lat%0d", tag, i), rc[i], ac[i] + 1);
         chk($sformatf("%s_cons%0d", tag, i), rc[i], rc[0] + i);
      end
      chk({tag, "_busy_during_rd"}, bad_busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      step(); step();
      chk("rst_ce", int'(ram_ce), 0);
      chk("rst_we", int'(ram_we), 0);
      chk("rst_adr", int'(ram_adr), 0);
      chk("rst_din", int'(ram_din), 0);
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_wr_ready", int'(wr_ready), 0);
`ifdef RAM_INIT_CLEAR_EN
      chk("rst_cmd_ready", int'(cmd_ready), 0);
      clr();
      rst_n = 1'b1;
      step();
      chk("clr_cmd_ready", int'(cmd_ready), 0);
      chk("clr_busy", int'(busy), 1);
      wait_idle("clr");
      chk("clr_nwr", wa.size(), 16);
      for (int i = 0; i < wa.size(); i++) begin
         chk($sformatf("clr_adr%0d", i), int'(wa[i]), i);
         chk($sformatf("clr_din%0d", i), int'(wd[i]), 0);
      end
      ex = {};
      for (int i = 0; i < 16; i++) ex.push_back(8'h00);
      read_check("clr_rd", 4'd0, 4'd15);
`else
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      rst_n = 1'b1;
      step();
`endif
      // 1: continuous write burst
      ex = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      write_burst("t1", 4'd3, 4'd3);
      // 2: read it back
      read_check("t2", 4'd3, 4'd3);
      // 3: address wrap
      ex = '{8'h01, 8'h02, 8'h03, 8'h04};
      write_burst("t3", 4'd14, 4'd3);
      read_check("t3r", 4'd14, 4'd3);
      // 4: throttled write with an ignored mid-burst command
      clr();
      send_cmd(1'b1, 4'd8, 4'd1);
      wr_beat(8'h55);
      chk("t4_ce_beat0", int'(ram_ce), 1);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'd0; cmd_len = 4'd3;
      chk("t4_cmd_ready_busy", int'(cmd_ready), 0);
      step();
      cmd_valid = 1'b0;
      chk("t4_bubble1", int'(ram_ce), 0);
      step();
      chk("t4_bubble2", int'(ram_ce), 0);
      wr_beat(8'h66);
      wr_valid = 1'b1; wr_data = 8'h77;
      chk("t4_wr_ready_idle", int'(wr_ready), 0);
      step();
      wr_valid = 1'b0;
      chk("t4_no_extra_ce", int'(ram_ce), 0);
      step();
      chk("t4_nwr", wa.size(), 2);
      if (wa.size() == 2) begin
         chk("t4_adr0", int'(wa[0]), 8);
         chk("t4_din0", int'(wd[0]), 'h55);
         chk("t4_adr1", int'(wa[1]), 9);
         chk("t4_din1", int'(wd[1]), 'h66);
      end
      chk("t4_no_reads", ra.size(), 0);
      chk("t4_busy", int'(busy), 0);
      // 5: reset during the second beat of a long read
      clr();
      send_cmd(1'b0, 4'd0, 4'd7);
      step();
      chk("t5_pre_rd_valid", int'(rd_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("t5_ce_async", int'(ram_ce), 0);
      chk("t5_rd_valid_async", int'(rd_valid), 0);
      step();
      clr();
      rst_n = 1'b1;
      step(); step();
`ifdef RAM_INIT_CLEAR_EN
      wait_idle("t5");
`endif
      chk("t5_busy", int'(busy), 0);
      chk("t5_no_stale", rd.size(), 0);
      chk("t5_cmd_ready", int'(cmd_ready), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
